// File: rtl/ru_write_arbiter_if.sv
// Bus bundle for ru_write_arbiter: two writeback requesters, issue/scoreboard lookups, RU write port.
// Forwarding signals exist only when RU_ARB_BYPASS_EN is defined.
interface ru_write_arbiter_if;
  logic        a_req;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_gnt;
  logic        b_req;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_gnt;
  logic        issue_vld;
  logic [4:0]  issue_rd;
  logic        issue_rdy;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        ru_wr;
  logic [4:0]  rd;
  logic [31:0] ru_data_wr;
  logic        underflow;
`ifdef RU_ARB_BYPASS_EN
  logic        rs1_fwd;
  logic        rs2_fwd;
  logic [31:0] fwd_data;

  modport slave (
    input  a_req, a_rd, a_data, b_req, b_rd, b_data, issue_vld, issue_rd, rs1, rs2,
    output a_gnt, b_gnt, issue_rdy, rs1_busy, rs2_busy, ru_wr, rd, ru_data_wr, underflow,
    output rs1_fwd, rs2_fwd, fwd_data
  );
  modport master (
    output a_req, a_rd, a_data, b_req, b_rd, b_data, issue_vld, issue_rd, rs1, rs2,
    input  a_gnt, b_gnt, issue_rdy, rs1_busy, rs2_busy, ru_wr, rd, ru_data_wr, underflow,
    input  rs1_fwd, rs2_fwd, fwd_data
  );
`else
  modport slave (
    input  a_req, a_rd, a_data, b_req, b_rd, b_data, issue_vld, issue_rd, rs1, rs2,
    output a_gnt, b_gnt, issue_rdy, rs1_busy, rs2_busy, ru_wr, rd, ru_data_wr, underflow
  );
  modport master (
    output a_req, a_rd, a_data, b_req, b_rd, b_data, issue_vld, issue_rd, rs1, rs2,
    input  a_gnt, b_gnt, issue_rdy, rs1_busy, rs2_busy, ru_wr, rd, ru_data_wr, underflow
  );
`endif
endinterface

// File: rtl/ru_write_arbiter.sv
// Round-robin arbiter for the single register-unit write port plus pending-write scoreboard.
// Optional forwarding of the in-flight write is enabled by defining RU_ARB_BYPASS_EN.
module ru_write_arbiter #(
  parameter int unsigned PendW = 2
) (
  input logic            clk,
  input logic            rst,
  ru_write_arbiter_if.slave bus
);

  localparam logic [0:0]       LastA  = 1'b0;
  localparam logic [0:0]       LastB  = 1'b1;
  localparam logic [PendW-1:0] CntMax = '1;

  logic [0:0]       last_q, last_d;
  logic [PendW-1:0] cnt_q [32];
  logic [PendW-1:0] cnt_d [32];
  logic             ru_wr_q, ru_wr_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      data_q, data_d;
  logic             underflow_q, underflow_d;

  logic        a_nz, b_nz, a_gnt, b_gnt, a_wr, b_wr, wr_fire, issue_rdy, issue_fire;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic [31:0] inc_vec, dec_vec;
  logic        rs1_hit, rs2_hit, rs1_busy_raw, rs2_busy_raw;

  // Rd==0 requests never touch the port, so they are granted unconditionally.
  always_comb begin
    a_nz  = bus.a_req && (bus.a_rd != 5'd0);
    b_nz  = bus.b_req && (bus.b_rd != 5'd0);
    a_gnt = !rst && bus.a_req && ((bus.a_rd == 5'd0) || !b_nz || (last_q != LastA));
    b_gnt = !rst && bus.b_req && ((bus.b_rd == 5'd0) || !a_nz || (last_q != LastB));
    a_wr  = a_gnt && a_nz;
    b_wr  = b_gnt && b_nz;
    wr_fire = a_wr || b_wr;
    wr_rd   = a_wr ? bus.a_rd : bus.b_rd;
    wr_data = a_wr ? bus.a_data : bus.b_data;
  end

  always_comb begin
    issue_rdy  = !rst && ((bus.issue_rd == 5'd0) || (cnt_q[bus.issue_rd] != CntMax));
    issue_fire = bus.issue_vld && issue_rdy && (bus.issue_rd != 5'd0);
    inc_vec    = issue_fire ? (32'd1 << bus.issue_rd) : 32'd0;
    dec_vec    = wr_fire ? (32'd1 << wr_rd) : 32'd0;
  end

  always_comb begin
    cnt_d       = cnt_q;
    underflow_d = underflow_q || (wr_fire && (cnt_q[wr_rd] == '0));
    for (int r = 1; r < 32; r++) begin
      if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + PendW'(1);
      end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - PendW'(1);
      end
    end
    cnt_d[0] = '0;
  end

  always_comb begin
    last_d  = a_wr ? LastA : (b_wr ? LastB : last_q);
    ru_wr_d = wr_fire;
    rd_d    = wr_fire ? wr_rd : rd_q;
    data_d  = wr_fire ? wr_data : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= LastB;
      cnt_q       <= '{default: '0};
      ru_wr_q     <= 1'b0;
      rd_q        <= 5'd0;
      data_q      <= 32'd0;
      underflow_q <= 1'b0;
    end else begin
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      ru_wr_q     <= ru_wr_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      underflow_q <= underflow_d;
    end
  end

  // Busy uses the pre-update counter; an in-flight write also counts as busy.
  always_comb begin
    rs1_hit      = ru_wr_q && (rd_q == bus.rs1);
    rs2_hit      = ru_wr_q && (rd_q == bus.rs2);
    rs1_busy_raw = (bus.rs1 != 5'd0) && ((cnt_q[bus.rs1] != '0) || rs1_hit);
    rs2_busy_raw = (bus.rs2 != 5'd0) && ((cnt_q[bus.rs2] != '0) || rs2_hit);
  end

`ifdef RU_ARB_BYPASS_EN
  logic rs1_fwd, rs2_fwd;

  always_comb begin
    rs1_fwd = (bus.rs1 != 5'd0) && rs1_hit && (cnt_q[bus.rs1] == '0);
    rs2_fwd = (bus.rs2 != 5'd0) && rs2_hit && (cnt_q[bus.rs2] == '0);
  end

  assign bus.rs1_fwd  = rs1_fwd;
  assign bus.rs2_fwd  = rs2_fwd;
  assign bus.fwd_data = data_q;
  assign bus.rs1_busy = rs1_busy_raw && !rs1_fwd;
  assign bus.rs2_busy = rs2_busy_raw && !rs2_fwd;
`else
  assign bus.rs1_busy = rs1_busy_raw;
  assign bus.rs2_busy = rs2_busy_raw;
`endif

  assign bus.a_gnt      = a_gnt;
  assign bus.b_gnt      = b_gnt;
  assign bus.issue_rdy  = issue_rdy;
  assign bus.ru_wr      = ru_wr_q;
  assign bus.rd         = rd_q;
  assign bus.ru_data_wr = data_q;
  assign bus.underflow  = underflow_q;

endmodule

// File: tb/tb_ru_write_arbiter.sv
// Directed self-checking bench for ru_write_arbiter (default build and RU_ARB_BYPASS_EN build).
module tb_ru_write_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ru_write_arbiter_if bus ();

  ru_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    bus.a_req     = 1'b0;
    bus.a_rd      = 5'd0;
    bus.a_data    = 32'd0;
    bus.b_req     = 1'b0;
    bus.b_rd      = 5'd0;
    bus.b_data    = 32'd0;
    bus.issue_vld = 1'b0;
    bus.issue_rd  = 5'd0;
  endtask

  task automatic do_reset();
    clear_req();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [4:0] r);
    bus.issue_vld = 1'b1;
    bus.issue_rd  = r;
    #1;
    check_eq("issue_rdy", 32'(bus.issue_rdy), 32'd1);
    step();
    bus.issue_vld = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    clear_req();
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd0;

    // 1. Reset: grants and issue blocked while held, clean state after release.
    step();
    bus.a_req = 1'b1; bus.a_rd = 5'd1; bus.b_req = 1'b1; bus.b_rd = 5'd2;
    bus.issue_vld = 1'b1; bus.issue_rd = 5'd3;
    #1;
    check_eq("rst_a_gnt", 32'(bus.a_gnt), 32'd0);
    check_eq("rst_b_gnt", 32'(bus.b_gnt), 32'd0);
    check_eq("rst_issue_rdy", 32'(bus.issue_rdy), 32'd0);
    step();
    clear_req();
    rst = 1'b0;
    #1;
    check_eq("rst_ru_wr", 32'(bus.ru_wr), 32'd0);
    check_eq("rst_rd", 32'(bus.rd), 32'd0);
    check_eq("rst_data", bus.ru_data_wr, 32'd0);
    check_eq("rst_underflow", 32'(bus.underflow), 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.rs1 = 5'(i);
      #1;
      check_eq("rst_rs1_busy", 32'(bus.rs1_busy), 32'd0);
    end

    // 2. Issue r5 then write it through requester A.
    step();
    bus.rs1 = 5'd5;
    bus.issue_vld = 1'b1; bus.issue_rd = 5'd5;
    #1;
    check_eq("t2_issue_rdy", 32'(bus.issue_rdy), 32'd1);
    check_eq("t2_busy_issue_cyc", 32'(bus.rs1_busy), 32'd0);
    step();
    clear_req();
    bus.a_req = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'hDEADBEEF;
    #1;
    check_eq("t2_a_gnt", 32'(bus.a_gnt), 32'd1);
    check_eq("t2_busy_pending", 32'(bus.rs1_busy), 32'd1);
    step();
    clear_req();
    #1;
    check_eq("t2_ru_wr", 32'(bus.ru_wr), 32'd1);
    check_eq("t2_rd", 32'(bus.rd), 32'd5);
    check_eq("t2_data", bus.ru_data_wr, 32'hDEADBEEF);
`ifdef RU_ARB_BYPASS_EN
    check_eq("t2_busy_inflight", 32'(bus.rs1_busy), 32'd0);
    check_eq("t2_rs1_fwd", 32'(bus.rs1_fwd), 32'd1);
`else
    check_eq("t2_busy_inflight", 32'(bus.rs1_busy), 32'd1);
`endif
    step();
    check_eq("t2_ru_wr_drop", 32'(bus.ru_wr), 32'd0);
    check_eq("t2_rd_hold", 32'(bus.rd), 32'd5);
    check_eq("t2_data_hold", bus.ru_data_wr, 32'hDEADBEEF);
    check_eq("t2_busy_done", 32'(bus.rs1_busy), 32'd0);

    // 3. Both requesters held from reset: A,B,A,B.
    do_reset();
    issue(5'd1); issue(5'd1); issue(5'd2); issue(5'd2);
    bus.a_req = 1'b1; bus.a_rd = 5'd1; bus.a_data = 32'h0000_00A1;
    bus.b_req = 1'b1; bus.b_rd = 5'd2; bus.b_data = 32'h0000_00B2;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t3_a_gnt", 32'(bus.a_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("t3_b_gnt", 32'(bus.b_gnt), (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
      check_eq("t3_rd", 32'(bus.rd), (i % 2 == 0) ? 32'd1 : 32'd2);
      check_eq("t3_data", bus.ru_data_wr, (i % 2 == 0) ? 32'h0000_00A1 : 32'h0000_00B2);
    end
    clear_req();
    #1;
    check_eq("t3_underflow", 32'(bus.underflow), 32'd0);

    // 4. A with Rd=0 alongside B with Rd=7: both granted, only r7 written, LAST moves to B.
    do_reset();
    issue(5'd7); issue(5'd1); issue(5'd2);
    bus.a_req = 1'b1; bus.a_rd = 5'd0; bus.a_data = 32'h1111_1111;
    bus.b_req = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'h7777_7777;
    #1;
    check_eq("t4_a_gnt", 32'(bus.a_gnt), 32'd1);
    check_eq("t4_b_gnt", 32'(bus.b_gnt), 32'd1);
    step();
    check_eq("t4_ru_wr", 32'(bus.ru_wr), 32'd1);
    check_eq("t4_rd", 32'(bus.rd), 32'd7);
    check_eq("t4_data", bus.ru_data_wr, 32'h7777_7777);
    bus.a_rd = 5'd1; bus.a_data = 32'h0000_0001;
    bus.b_rd = 5'd2; bus.b_data = 32'h0000_0002;
    #1;
    check_eq("t4_last_a_gnt", 32'(bus.a_gnt), 32'd1);
    check_eq("t4_last_b_gnt", 32'(bus.b_gnt), 32'd0);
    step();
    check_eq("t4_rd_a", 32'(bus.rd), 32'd1);
    bus.a_req = 1'b0;
    #1;
    check_eq("t4_b_alone_gnt", 32'(bus.b_gnt), 32'd1);
    step();
    clear_req();
    check_eq("t4_rd_b", 32'(bus.rd), 32'd2);
    step();
    check_eq("t4_ru_wr_idle", 32'(bus.ru_wr), 32'd0);
    check_eq("t4_underflow", 32'(bus.underflow), 32'd0);

    // 5. Counter saturation at 3, then simultaneous issue+grant leaves the count unchanged.
    do_reset();
    bus.rs2 = 5'd9;
    issue(5'd9); issue(5'd9); issue(5'd9);
    bus.issue_vld = 1'b1; bus.issue_rd = 5'd9;
    #1;
    check_eq("t5_full_rdy", 32'(bus.issue_rdy), 32'd0);
    check_eq("t5_rs2_busy", 32'(bus.rs2_busy), 32'd1);
    step();
    clear_req();
    bus.a_req = 1'b1; bus.a_rd = 5'd9; bus.a_data = 32'h9;
    step();
    bus.issue_vld = 1'b1; bus.issue_rd = 5'd9;
    #1;
    check_eq("t5_both_rdy", 32'(bus.issue_rdy), 32'd1);
    check_eq("t5_both_gnt", 32'(bus.a_gnt), 32'd1);
    step();
    clear_req();
    issue(5'd9);
    bus.issue_vld = 1'b1; bus.issue_rd = 5'd9;
    #1;
    check_eq("t5_refull_rdy", 32'(bus.issue_rdy), 32'd0);
    clear_req();
    check_eq("t5_underflow", 32'(bus.underflow), 32'd0);

    // 6. Write to an idle register: still written, sticky underflow.
    do_reset();
    bus.b_req = 1'b1; bus.b_rd = 5'd3; bus.b_data = 32'hCAFEF00D;
    #1;
    check_eq("t6_b_gnt", 32'(bus.b_gnt), 32'd1);
    step();
    clear_req();
    bus.rs1 = 5'd3;
    #1;
    check_eq("t6_ru_wr", 32'(bus.ru_wr), 32'd1);
    check_eq("t6_rd", 32'(bus.rd), 32'd3);
    check_eq("t6_underflow", 32'(bus.underflow), 32'd1);
`ifdef RU_ARB_BYPASS_EN
    check_eq("t6_rs1_fwd", 32'(bus.rs1_fwd), 32'd1);
    check_eq("t6_rs1_busy", 32'(bus.rs1_busy), 32'd0);
    check_eq("t6_fwd_data", bus.fwd_data, 32'hCAFEF00D);
`else
    check_eq("t6_rs1_busy", 32'(bus.rs1_busy), 32'd1);
`endif
    step();
    step();
    check_eq("t6_underflow_sticky", 32'(bus.underflow), 32'd1);
    do_reset();
    #1;
    check_eq("t6_underflow_clr", 32'(bus.underflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
